// File: rtl/paddle_input_sched_if.sv
// paddle_input_sched_if: move-command valid/ready channel between the scheduler and the game logic
interface paddle_input_sched_if;
    logic cmd_valid;
    logic cmd_ready;
    logic cmd_player;
    logic cmd_dir;
    modport master(output cmd_valid, cmd_player, cmd_dir, input cmd_ready);
    modport slave(input cmd_valid, cmd_player, cmd_dir, output cmd_ready);
endinterface

// File: rtl/paddle_input_sched.sv
// paddle_input_sched: keypad hits -> debounced, auto-repeating paddle moves, round-robin between two players
// Optional macro REPEAT_ACCEL_EN: halves the repeat interval after the 4th repeat of a held key.
module paddle_input_sched #(
    parameter logic [15:0] DEBOUNCE_CYC = 16'd50000,
    parameter logic [15:0] REPEAT_CYC   = 16'd40000,
    parameter logic [7:0]  HOLD_WIN     = 8'd8,
    parameter logic [3:0]  P1_UP_KEY    = 4'd1,
    parameter logic [3:0]  P1_DN_KEY    = 4'd7,
    parameter logic [3:0]  P2_UP_KEY    = 4'd10,
    parameter logic [3:0]  P2_DN_KEY    = 4'd12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        keypressed,
    input  logic [3:0]                  keys,
    paddle_input_sched_if.master        cmd,
    output logic                        busy
);
    typedef enum logic [1:0] {IDLE, DEBOUNCE, REPEAT} state_t;

    // key index k: bit 1 = player, bit 0 = 1 for down
    logic [3:0][3:0] key_code;
    logic [3:0]      held, conflict, set_ev, pend;
    logic [1:0]      pend_player, sel_key;
    logic            cmd_valid, cmd_player, cmd_dir, rr, pick, handshake;

    assign key_code    = {P2_DN_KEY, P2_UP_KEY, P1_DN_KEY, P1_UP_KEY};
    assign conflict    = {{2{held[3] & held[2]}}, {2{held[1] & held[0]}}};
    assign pend_player = {pend[3] | pend[2], pend[1] | pend[0]};
    assign sel_key     = {cmd_player, ~cmd_dir};
    assign handshake   = cmd_valid & cmd.cmd_ready;
    assign pick        = pend_player[rr] ? rr : ~rr;
    assign busy        = |held;

    assign cmd.cmd_valid  = cmd_valid;
    assign cmd.cmd_player = cmd_player;
    assign cmd.cmd_dir    = cmd_dir;

    for (genvar k = 0; k < 4; k++) begin : g_key
        logic [7:0]  tmr;
        logic [15:0] cnt, cnt_nx, interval;
        state_t      state, state_nx;
        logic        set, pend_r, on_bus;
`ifdef REPEAT_ACCEL_EN
        logic [2:0]  rep, rep_nx;
        assign interval = (rep == 3'd4) ? (REPEAT_CYC >> 1) : REPEAT_CYC;
`else
        assign interval = REPEAT_CYC;
`endif
        assign held[k]   = tmr != 8'd0;
        assign set_ev[k] = set;
        assign pend[k]   = pend_r;
        assign on_bus    = cmd_valid && sel_key == 2'(k);

        // Presence timer: reload on a matching hit, otherwise drain to zero
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n)
                tmr <= 8'd0;
            else
                tmr <= (keypressed && keys == key_code[k]) ? HOLD_WIN : (held[k] ? tmr - 8'd1 : 8'd0);

        // Debounce/repeat FSM state and counter registers
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                state <= IDLE;
                cnt   <= 16'd0;
`ifdef REPEAT_ACCEL_EN
                rep   <= 3'd0;
`endif
            end else begin
                state <= state_nx;
                cnt   <= cnt_nx;
`ifdef REPEAT_ACCEL_EN
                rep   <= rep_nx;
`endif
            end

        // Next state: release or an up/down conflict always returns to IDLE
        always_comb begin
            state_nx = state;
            cnt_nx   = cnt + 16'd1;
            set      = 1'b0;
            if (!held[k] || conflict[k]) begin
                state_nx = IDLE;
                cnt_nx   = 16'd0;
            end else begin
                case (state)
                    IDLE: begin
                        state_nx = DEBOUNCE;
                        cnt_nx   = 16'd0;
                    end
                    DEBOUNCE: if (cnt == DEBOUNCE_CYC - 16'd1) begin
                        set      = 1'b1;
                        state_nx = REPEAT;
                        cnt_nx   = 16'd0;
                    end
                    REPEAT: if (cnt == interval - 16'd1) begin
                        set    = 1'b1;
                        cnt_nx = 16'd0;
                    end
                    default: begin
                        state_nx = IDLE;
                        cnt_nx   = 16'd0;
                    end
                endcase
            end
`ifdef REPEAT_ACCEL_EN
            rep_nx = (state_nx == IDLE) ? 3'd0 : (state == REPEAT && set && rep != 3'd4) ? rep + 3'd1 : rep;
`endif
        end

        // Pending flag: a new set beats a grant; release drops it unless it is the command on the bus
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n)
                pend_r <= 1'b0;
            else
                pend_r <= set ? 1'b1 : ((on_bus && handshake) || (!held[k] && !on_bus)) ? 1'b0 : pend_r;
    end

    // Command register and round-robin pointer; payload frozen while waiting for ready
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cmd_valid  <= 1'b0;
            cmd_player <= 1'b0;
            cmd_dir    <= 1'b0;
            rr         <= 1'b0;
        end else if (cmd_valid) begin
            if (handshake) begin
                cmd_valid <= 1'b0;
                rr        <= ~cmd_player;
            end
        end else if (|pend_player) begin
            cmd_valid  <= 1'b1;
            cmd_player <= pick;
            cmd_dir    <= pick ? pend[2] : pend[0];
        end
endmodule
